spi_xfer_ctrl: RTL and testbench

//  Transfer sequencer for the SPI master. Starts and ends a transfer, drives tip/last_clk into the

---
 rtl/spi_xfer_ctrl.sv | 135 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: start/stop, bit counting, shift register,
// slave select, done pulse and sticky interrupt.
module spi_xfer_ctrl #(
   parameter int MAX_CHAR      = 128,
   parameter int CHAR_LEN_BITS = 7,
   parameter int SS_NB         = 8
) (
   input  logic                     wb_clk_in,
   input  logic                     wb_rst,
   input  logic                     go,
   input  logic [CHAR_LEN_BITS-1:0] char_len,
   input  logic                     lsb,
   input  logic                     tx_negedge,
   input  logic                     rx_negedge,
   input  logic                     ass,
   input  logic                     ie,
   input  logic                     int_ack,
   input  logic [SS_NB-1:0]         ss_sel,
   input  logic [MAX_CHAR-1:0]      tx_data,
   input  logic                     miso,
   input  logic                     cpol_0,
   input  logic                     cpol_1,
   output logic                     tip,
   output logic                     last_clk,
   output logic                     mosi,
   output logic [SS_NB-1:0]         ss_pad_o,
   output logic [MAX_CHAR-1:0]      rx_data,
   output logic                     done,
   output logic                     int_o
);

   localparam int CW = CHAR_LEN_BITS + 1;
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t state, state_nxt;

   logic [MAX_CHAR-1:0]      sreg;
   logic [CW-1:0]            len, len_m1;
   logic [CW-1:0]            bit_cnt, tx_cnt, rx_cnt, tx_nxt;
   logic [CHAR_LEN_BITS-1:0] tx_idx, rx_idx, first_idx;
   logic                     first_rise;
   logic                     p0, p1;
   logic                     tx_pulse, rx_pulse;
   logic                     start, end_x;

   // Simultaneous pulses are illegal; the falling pulse wins.
   assign p0 = cpol_0 & ~cpol_1;
   assign p1 = cpol_1;

   assign len    = (char_len == '0) ? CW'(MAX_CHAR) : {1'b0, char_len};
   assign len_m1 = len - ONE;
   assign tx_nxt = tx_cnt + ONE;

   // Sequence number to bit position; MSB-first counts down from len-1.
   assign tx_idx    = lsb ? tx_nxt[CHAR_LEN_BITS-1:0]
                          : len_m1[CHAR_LEN_BITS-1:0] - tx_nxt[CHAR_LEN_BITS-1:0];
   assign rx_idx    = lsb ? rx_cnt[CHAR_LEN_BITS-1:0]
                          : len_m1[CHAR_LEN_BITS-1:0] - rx_cnt[CHAR_LEN_BITS-1:0];
   assign first_idx = lsb ? '0 : len_m1[CHAR_LEN_BITS-1:0];

   assign start    = (state == IDLE) & go;
   assign end_x    = (state == XFER) & p1 & (bit_cnt == ONE);
   assign tx_pulse = tx_negedge ? p1 : (p0 & ~first_rise);
   assign rx_pulse = rx_negedge ? p1 : p0;

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (go)    state_nxt = XFER;
         XFER: if (end_x) state_nxt = IDLE;
         default:         state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tip = (state == XFER);
   end

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) begin
         sreg       <= '0;
         mosi       <= 1'b0;
         bit_cnt    <= '0;
         tx_cnt     <= '0;
         rx_cnt     <= '0;
         first_rise <= 1'b0;
         last_clk   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= end_x;
         if (start) begin
            sreg       <= tx_data;
            mosi       <= tx_data[first_idx];
            bit_cnt    <= len;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            first_rise <= 1'b1;
            last_clk   <= 1'b0;
         end else if (tip) begin
            if (p1) bit_cnt <= bit_cnt - ONE;
            if (p0) first_rise <= 1'b0;
            if (tx_pulse && tx_cnt != len_m1) begin
               tx_cnt <= tx_nxt;
               mosi   <= sreg[tx_idx];
            end
            // Writes land only on positions already sent, ahead of tx reads.
            if (rx_pulse && rx_cnt != len) begin
               sreg[rx_idx] <= miso;
               rx_cnt       <= rx_cnt + ONE;
            end
            if (end_x)
               last_clk <= 1'b0;
            else if (p0 && bit_cnt == ONE)
               last_clk <= 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst)           int_o <= 1'b0;
      else if (done && ie)  int_o <= 1'b1;
      else if (int_ack)     int_o <= 1'b0;
   end

   assign rx_data  = sreg;
   assign ss_pad_o = ~(ss_sel & {SS_NB{tip | ~ass}});

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: bench-side clockgen pulses, loopback MISO,
// scoreboard of expected rx data and MOSI sequences.
module tb_spi_xfer_ctrl;

   localparam int MC = 128;
   localparam int CL = 7;
   localparam int SS = 8;

   logic          wb_clk_in, wb_rst, go, lsb, tx_negedge, rx_negedge;
   logic          ass, ie, int_ack, miso, cpol_0, cpol_1, miso_inv;
   logic [CL-1:0] char_len;
   logic [SS-1:0] ss_sel, ss_pad_o;
   logic [MC-1:0] tx_data, rx_data;
   logic          tip, last_clk, mosi, done, int_o;

   typedef struct {
      logic [MC-1:0] rx;
      logic [MC-1:0] mask;
      logic [MC-1:0] mseq;
      int            len;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   int            falls, rises, ri, done_cnt, ss_bad;
   logic [MC-1:0] lc_mask, mseq;

   spi_xfer_ctrl #(.MAX_CHAR(MC), .CHAR_LEN_BITS(CL), .SS_NB(SS)) dut (
      .wb_clk_in (wb_clk_in),
      .wb_rst    (wb_rst),
      .go        (go),
      .char_len  (char_len),
      .lsb       (lsb),
      .tx_negedge(tx_negedge),
      .rx_negedge(rx_negedge),
      .ass       (ass),
      .ie        (ie),
      .int_ack   (int_ack),
      .ss_sel    (ss_sel),
      .tx_data   (tx_data),
      .miso      (miso),
      .cpol_0    (cpol_0),
      .cpol_1    (cpol_1),
      .tip       (tip),
      .last_clk  (last_clk),
      .mosi      (mosi),
      .ss_pad_o  (ss_pad_o),
      .rx_data   (rx_data),
      .done      (done),
      .int_o     (int_o)
   );

   assign miso = mosi ^ miso_inv;

   initial wb_clk_in = 1'b0;
   always #5 wb_clk_in = ~wb_clk_in;

   always @(posedge wb_clk_in)
      if (!wb_rst)
         assert (!(cpol_0 && cpol_1))
         else $error("FAIL cpol_both got=1 exp=0");

   task automatic chk(input string tag, input logic [MC-1:0] got,
                      input logic [MC-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MC-1:0] len_mask(input int len);
      logic [MC-1:0] m;
      m = '0;
      for (int k = 0; k < len; k++) m[k] = 1'b1;
      return m;
   endfunction

   function automatic logic [MC-1:0] bit_seq(input logic [MC-1:0] d,
                                             input int len, input logic lf);
      logic [MC-1:0] s;
      s = '0;
      for (int k = 0; k < len; k++) s[k] = lf ? d[k] : d[len-1-k];
      return s;
   endfunction

   // Drive a go pulse and record what the transfer must produce.
   task automatic start_go(input logic [MC-1:0] d, input int len);
      exp_t e;
      e.len  = len;
      e.mask = len_mask(len);
      e.rx   = (miso_inv ? ~d : d) & e.mask;
      e.mseq = bit_seq(d, len, lsb);
      sb.push_back(e);
      tx_data = d;
      go = 1'b1;
      @(negedge wb_clk_in);
      go = 1'b0;
   endtask

   // Clockgen model: rise/fall pulses on alternate even cycles until tip
   // drops; returns at the negedge of the done cycle.
   task automatic clk_run(input int budget, input int go_mid);
      int n;
      bit hi;
      n = 0; hi = 0;
      falls = 0; rises = 0; ri = 0; done_cnt = 0; ss_bad = 0;
      lc_mask = '0; mseq = '0;
      while (tip === 1'b1 && n < budget) begin
         if (ss_pad_o !== ~ss_sel) ss_bad++;
         cpol_0 = 1'b0; cpol_1 = 1'b0;
         go = (n == go_mid);
         if (n == go_mid) tx_data = ~tx_data;
         if (n % 2 == 0) begin
            if (!hi) begin
               if (!last_clk) begin
                  cpol_0 = 1'b1; rises++; hi = 1;
                  if (!rx_negedge && ri < MC) begin mseq[ri] = mosi; ri++; end
               end
            end else begin
               cpol_1 = 1'b1; hi = 0;
               if (falls < MC) lc_mask[falls] = last_clk;
               falls++;
               if (rx_negedge && ri < MC) begin mseq[ri] = mosi; ri++; end
            end
         end
         @(negedge wb_clk_in);
         n++;
         if (done) done_cnt++;
      end
      cpol_0 = 1'b0; cpol_1 = 1'b0; go = 1'b0;
   endtask

   // Compare the finished transfer with the oldest scoreboard entry.
   task automatic finish_xfer(input string tag);
      exp_t e;
      chk({tag, "_timeout"}, tip, 1'b0);
      chk({tag, "_sb"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rx"}, rx_data & e.mask, e.rx);
         chk({tag, "_mosi"}, mseq, e.mseq);
         chk({tag, "_falls"}, falls, e.len);
         chk({tag, "_lastclk"}, lc_mask, MC'(1) << (e.len - 1));
         chk({tag, "_done"}, done_cnt, 1);
         chk({tag, "_ss"}, ss_bad, 0);
      end
   endtask

   initial begin
      wb_rst = 1'b1; go = 1'b0; lsb = 1'b0; tx_negedge = 1'b1;
      rx_negedge = 1'b0; ass = 1'b1; ie = 1'b0; int_ack = 1'b0;
      ss_sel = 8'h04; tx_data = '0; cpol_0 = 1'b0; cpol_1 = 1'b0;
      miso_inv = 1'b0; char_len = 7'd8;
      repeat (3) @(negedge wb_clk_in);
      chk("rst_tip", tip, 1'b0);
      chk("rst_lastclk", last_clk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_int", int_o, 1'b0);
      chk("rst_rx", rx_data, '0);
      chk("rst_ss", ss_pad_o, 8'hFF);
      wb_rst = 1'b0;
      @(negedge wb_clk_in);

      // 8-bit MSB first, loopback, auto slave select
      start_go(MC'(8'hA5), 8);
      chk("x8_tip", tip, 1'b1);
      chk("x8_ss_on", ss_pad_o, 8'hFB);
      clk_run(200, -1);
      finish_xfer("x8");
      @(negedge wb_clk_in);
      chk("x8_done_clr", done, 1'b0);
      chk("x8_ss_off", ss_pad_o, 8'hFF);
      chk("x8_no_int", int_o, 1'b0);

      // manual slave select follows ss_sel while idle
      ass = 1'b0;
      #1 chk("ass0_idle", ss_pad_o, 8'hFB);
      @(negedge wb_clk_in);

      // full 128-bit LSB first
      char_len = 7'd0; lsb = 1'b1;
      start_go(MC'(1), MC);
      clk_run(2000, -1);
      finish_xfer("x128");
      @(negedge wb_clk_in);
      chk("x128_ss_idle", ss_pad_o, 8'hFB);
      ass = 1'b1;

      // 13-bit LSB first, other edge pairing, inverted MISO
      char_len = 7'd13; tx_negedge = 1'b0; rx_negedge = 1'b1;
      miso_inv = 1'b1;
      start_go(MC'(16'h1A5C), 13);
      clk_run(300, -1);
      finish_xfer("x13");
      @(negedge wb_clk_in);

      // 5-bit MSB first, both edges on fall, interrupt with ack in done cycle
      char_len = 7'd5; lsb = 1'b0; tx_negedge = 1'b1; rx_negedge = 1'b1;
      miso_inv = 1'b0; ie = 1'b1;
      start_go(MC'(5'b10110), 5);
      clk_run(200, -1);
      int_ack = 1'b1;
      finish_xfer("x5");
      @(negedge wb_clk_in);
      int_ack = 1'b0;
      chk("int_set_wins", int_o, 1'b1);
      @(negedge wb_clk_in);
      chk("int_sticky", int_o, 1'b1);
      int_ack = 1'b1;
      @(negedge wb_clk_in);
      int_ack = 1'b0;
      chk("int_ack_clr", int_o, 1'b0);
      ie = 1'b0;

      // go mid-transfer ignored, go in done cycle accepted
      char_len = 7'd8; rx_negedge = 1'b0;
      start_go(MC'(8'h3C), 8);
      clk_run(200, 7);
      chk("b2b_gap", tip, 1'b0);
      finish_xfer("b2b1");
      start_go(MC'(8'hC9), 8);
      chk("b2b_restart", tip, 1'b1);
      clk_run(200, -1);
      finish_xfer("b2b2");
      @(negedge wb_clk_in);

      // reset after three falls aborts the transfer
      ie = 1'b1; tx_data = MC'(8'hF0); go = 1'b1;
      @(negedge wb_clk_in);
      go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cpol_0 = 1'b1;
         @(negedge wb_clk_in);
         cpol_0 = 1'b0; cpol_1 = 1'b1;
         @(negedge wb_clk_in);
         cpol_1 = 1'b0;
      end
      chk("abort_pre_tip", tip, 1'b1);
      wb_rst = 1'b1;
      #1;
      chk("abort_tip", tip, 1'b0);
      chk("abort_ss", ss_pad_o, 8'hFF);
      @(negedge wb_clk_in);
      chk("abort_rx", rx_data, '0);
      chk("abort_done", done, 1'b0);
      wb_rst = 1'b0;
      repeat (2) @(negedge wb_clk_in);
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_int", int_o, 1'b0);
      chk("abort_idle", tip, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
